// File: rtl/reg_scan_checker.sv
// Run-and-verify controller: counts N execution cycles while tallying regfile writes,
// then scans registers 0-31 through read port A against an expected-value ROM.
module reg_scan_checker #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WCNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        num_cycles,
    input  logic              ctrl_writeEnable,
    input  logic [4:0]        ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    output logic              test_mode,
    output logic [4:0]        test_readReg,
    input  logic [DATA_W-1:0] data_readRegA,
    output logic [4:0]        exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic [WCNT_W-1:0] write_count,
    output logic [5:0]        error_count,
    output logic              first_fail_valid,
    output logic [4:0]        first_fail_reg,
    output logic              done,
    output logic              pass
);

    typedef enum logic [2:0] {StIdle, StRun, StPrime, StScan, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        cycle_cnt_q, cycle_cnt_d;
    logic [4:0]        k_q, k_d;
    logic [WCNT_W-1:0] write_count_q, write_count_d;
    logic [5:0]        error_count_q, error_count_d;
    logic              ff_valid_q, ff_valid_d;
    logic [4:0]        ff_reg_q, ff_reg_d;
    logic              test_mode_q, test_mode_d;
    logic [4:0]        read_reg_q, read_reg_d;
    logic [4:0]        exp_addr_q, exp_addr_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    // Write data is observed for debug only.
    logic unused_write_data;
    assign unused_write_data = ^data_writeReg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            n_q           <= '0;
            cycle_cnt_q   <= '0;
            k_q           <= '0;
            write_count_q <= '0;
            error_count_q <= '0;
            ff_valid_q    <= 1'b0;
            ff_reg_q      <= '0;
            test_mode_q   <= 1'b0;
            read_reg_q    <= '0;
            exp_addr_q    <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            cycle_cnt_q   <= cycle_cnt_d;
            k_q           <= k_d;
            write_count_q <= write_count_d;
            error_count_q <= error_count_d;
            ff_valid_q    <= ff_valid_d;
            ff_reg_q      <= ff_reg_d;
            test_mode_q   <= test_mode_d;
            read_reg_q    <= read_reg_d;
            exp_addr_q    <= exp_addr_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        cycle_cnt_d   = cycle_cnt_q;
        k_d           = k_q;
        write_count_d = write_count_q;
        error_count_d = error_count_q;
        ff_valid_d    = ff_valid_q;
        ff_reg_d      = ff_reg_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    write_count_d = '0;
                    error_count_d = '0;
                    ff_valid_d    = 1'b0;
                    ff_reg_d      = '0;
                    n_d           = num_cycles;
                    cycle_cnt_d   = '0;
                    state_d       = (num_cycles != 8'd0) ? StRun : StPrime;
                end
            end
            StRun: begin
                if (ctrl_writeEnable && (ctrl_writeReg != 5'd0) && (write_count_q != '1)) begin
                    write_count_d = write_count_q + 1'b1;
                end
                if (cycle_cnt_q == n_q - 8'd1) begin
                    state_d = StPrime;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 8'd1;
                end
            end
            StPrime: begin
                k_d     = '0;
                state_d = StScan;
            end
            StScan: begin
                // exp_data was addressed last cycle, so it belongs to register k.
                if (exp_data != data_readRegA) begin
                    error_count_d = error_count_q + 6'd1;
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_reg_d   = k_q;
                    end
                end
                if (k_q == 5'd31) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered copies of what the next state will present.
        test_mode_d = (state_d == StPrime) || (state_d == StScan);
        read_reg_d  = (state_d == StScan) ? k_d : 5'd0;
        exp_addr_d  = (state_d == StScan) ? k_d + 5'd1 : 5'd0;
        done_d      = (state_d == StDone);
        pass_d      = done_d && (error_count_d == 6'd0);
    end

    assign test_mode        = test_mode_q;
    assign test_readReg     = read_reg_q;
    assign exp_addr         = exp_addr_q;
    assign write_count      = write_count_q;
    assign error_count      = error_count_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_reg   = ff_reg_q;
    assign done             = done_q;
    assign pass             = pass_q;

endmodule

// File: tb/tb_reg_scan_checker.sv
// Randomized bench for reg_scan_checker: regfile/ROM environment, behavioural model,
// per-cycle compare process and a few literal expectations.
module tb_reg_scan_checker;

    localparam int DW = 32;
    localparam int WW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    num_cycles = 8'd0;
    logic          ctrl_writeEnable = 1'b0;
    logic [4:0]    ctrl_writeReg = 5'd0;
    logic [DW-1:0] data_writeReg = '0;
    logic          test_mode;
    logic [4:0]    test_readReg;
    logic [DW-1:0] data_readRegA;
    logic [4:0]    exp_addr;
    logic [DW-1:0] exp_data;
    logic [WW-1:0] write_count;
    logic [5:0]    error_count;
    logic          first_fail_valid;
    logic [4:0]    first_fail_reg;
    logic          done;
    logic          pass;

    logic [DW-1:0] regfile [32];
    logic [DW-1:0] rom [32];

    int n_chk = 0;
    int n_bad = 0;
    bit rand_wr = 1'b0;
    bit rand_start = 1'b0;

    reg_scan_checker #(.DATA_W(DW), .WCNT_W(WW)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .num_cycles       (num_cycles),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .test_mode        (test_mode),
        .test_readReg     (test_readReg),
        .data_readRegA    (data_readRegA),
        .exp_addr         (exp_addr),
        .exp_data         (exp_data),
        .write_count      (write_count),
        .error_count      (error_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_reg   (first_fail_reg),
        .done             (done),
        .pass             (pass)
    );

    always #5 clock = ~clock;

    // Environment: combinational regfile port, one-cycle-latency ROM.
    assign data_readRegA = regfile[test_readReg];
    always @(posedge clock) exp_data <= rom[exp_addr];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: edges since the accepted start, run length, write tally and
    // the scan outcome computed from the arrays when the run begins.
    bit m_seen = 1'b0;
    bit m_active = 1'b0;
    int m_t = 0;
    int m_n = 0;
    int m_wc = 0;
    int e_err = 0;
    int e_ff = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_active = 1'b0;
            m_wc = 0;
        end else if (start && (!m_active || m_t >= m_n + 33)) begin
            m_active = 1'b1;
            m_t = 0;
            m_n = int'(num_cycles);
            m_wc = 0;
            e_err = 0;
            e_ff = -1;
            for (int i = 0; i < 32; i++) begin
                if (rom[i] !== regfile[i]) begin
                    e_err++;
                    if (e_ff < 0) e_ff = i;
                end
            end
        end else if (m_active) begin
            if (m_t < m_n && ctrl_writeEnable && ctrl_writeReg != 5'd0 && m_wc < 65535) m_wc++;
            if (m_t < m_n + 33) m_t++;
        end
        m_seen = 1'b1;
    end

    always @(negedge clock) begin
        if (m_seen) begin
            if (!m_active) begin
                chk("idle_test_mode", test_mode, 0);
                chk("idle_done", done, 0);
                chk("idle_pass", pass, 0);
                chk("idle_error_count", error_count, 0);
                chk("idle_write_count", write_count, 0);
                chk("idle_ff_valid", first_fail_valid, 0);
            end else begin
                chk("test_mode", test_mode, longint'(m_t >= m_n && m_t <= m_n + 32));
                chk("done", done, longint'(m_t >= m_n + 33));
                chk("write_count", write_count, m_wc);
                if (m_t == m_n) chk("prime_exp_addr", exp_addr, 0);
                if (m_t > m_n && m_t <= m_n + 32) begin
                    chk("scan_read_reg", test_readReg, m_t - m_n - 1);
                    chk("scan_exp_addr", exp_addr, (m_t - m_n) % 32);
                end
                if (m_t >= m_n + 33) begin
                    chk("error_count", error_count, e_err);
                    chk("ff_valid", first_fail_valid, longint'(e_err != 0));
                    if (e_err != 0) chk("ff_reg", first_fail_reg, e_ff);
                    chk("pass", pass, longint'(e_err == 0));
                end else begin
                    chk("pass_early", pass, 0);
                end
            end
        end
    end

    task automatic cycle();
        @(negedge clock);
        if (rand_wr) begin
            ctrl_writeEnable = 1'($urandom);
            ctrl_writeReg = 5'($urandom);
            data_writeReg = $urandom;
        end
        if (rand_start) start = ($urandom_range(0, 15) == 0);
    endtask

    // Called at a negedge; returns just after the edge that samples start.
    task automatic launch(input int n);
        start = 1'b1;
        num_cycles = 8'(n);
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 400) begin
            cycle();
            lat++;
        end
        if (!done) chk("done_timeout", done, 1);
        start = 1'b0;
    endtask

    task automatic fill_match();
        for (int i = 0; i < 32; i++) begin
            regfile[i] = '0;
            rom[i] = '0;
        end
    endtask

    int lat;

    initial begin
        fill_match();
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        chk("rst_test_mode", test_mode, 0);
        chk("rst_exp_addr", exp_addr, 0);
        chk("rst_read_reg", test_readReg, 0);

        // N=10, matching contents.
        regfile[1] = 32'd5;   rom[1] = 32'd5;
        regfile[2] = -32'sd3; rom[2] = -32'sd3;
        rand_wr = 1'b1;
        launch(10);
        wait_done(0, lat);
        chk("lat_n10", lat, 43);
        chk("pass_n10", pass, 1);
        chk("err_n10", error_count, 0);
        chk("ffv_n10", first_fail_valid, 0);

        // Two mismatches, r7 first.
        rom[7] = 32'd100; regfile[7] = 32'd99;
        rom[20] = 32'd1;
        launch($urandom_range(1, 20));
        wait_done(0, lat);
        chk("err_two", error_count, 2);
        chk("ff_reg_two", first_fail_reg, 7);
        chk("pass_two", pass, 0);

        // Directed writes: r0, r3, r3, r5 in RUN, r7 just after.
        fill_match();
        rand_wr = 1'b0;
        ctrl_writeEnable = 1'b0;
        launch(4);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg = 5'd0; cycle();
        ctrl_writeReg = 5'd3; cycle();
        ctrl_writeReg = 5'd3; cycle();
        ctrl_writeReg = 5'd5; cycle();
        ctrl_writeReg = 5'd7; cycle();
        ctrl_writeEnable = 1'b0;
        wait_done(5, lat);
        chk("wcnt_directed", write_count, 3);

        // N=0, start pulsed mid-scan is ignored, restart from DONE clears counts.
        rom[9] = 32'h1234;
        rand_wr = 1'b1;
        launch(0);
        lat = 0;
        repeat (10) begin cycle(); lat++; end
        start = 1'b1;
        cycle();
        lat++;
        start = 1'b0;
        wait_done(lat, lat);
        chk("lat_n0", lat, 33);
        chk("wcnt_n0", write_count, 0);
        chk("err_n0", error_count, 1);
        chk("ff_reg_n0", first_fail_reg, 9);
        launch(3);
        chk("restart_err", error_count, 0);
        chk("restart_ffv", first_fail_valid, 0);
        chk("restart_done", done, 0);
        wait_done(0, lat);

        // Reset during SCAN k=12, then a clean run.
        launch(5);
        repeat (5 + 13) cycle();
        chk("pre_rst_read_reg", test_readReg, 12);
        chk("pre_rst_test_mode", test_mode, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_test_mode", test_mode, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", error_count, 0);
        launch(7);
        wait_done(0, lat);
        chk("post_rst_done", done, 1);

        // Entire range mismatched.
        for (int i = 0; i < 32; i++) begin
            regfile[i] = '0;
            rom[i] = 32'hFFFF_FFFF;
        end
        launch($urandom_range(0, 8));
        wait_done(0, lat);
        chk("err_all", error_count, 32);
        chk("ff_reg_all", first_fail_reg, 0);

        // Random runs with stray start pulses.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) begin
                regfile[i] = $urandom;
                rom[i] = ($urandom_range(0, 3) == 0) ? $urandom : regfile[i];
            end
            rand_start = 1'b1;
            launch($urandom_range(0, 40));
            wait_done(0, lat);
            rand_start = 1'b0;
            start = 1'b0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
